// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types used across the pipeline blocks.
package cpu_types_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

endpackage

// File: rtl/pipe_ctrl_pkg.sv
// Types and constants shared by the pipeline controller and its helpers.
package pipe_ctrl_pkg;

    import cpu_types_pkg::*;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam regbits_t REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the datapath and the pipeline controller.
// Optional perf counters appear only when PIPE_PERF_EN is defined.
interface pipeline_ctrl_if
`ifdef PIPE_PERF_EN
    #(parameter int unsigned CNT_W = 32)
`endif
    ();

    import cpu_types_pkg::*;

    logic     ihit;
    logic     dhit;
    logic     mem_dREN;
    logic     mem_dWEN;
    logic     ex_MemRead;
    regbits_t ex_wsel;
    regbits_t id_rs;
    regbits_t id_rt;
    logic     id_uses_rt;
    logic     ex_brtaken;
    logic     id_jump;
    logic     wb_halt;

    logic     pc_en;
    logic     ifid_en;
    logic     idex_en;
    logic     exmem_en;
    logic     memwb_en;
    logic     ifid_flush;
    logic     idex_flush;
    logic     exmem_flush;
    logic     memwb_flush;
    logic     halted;
`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    // Datapath side: supplies status, consumes enables.
    modport master (
        output ihit, dhit, mem_dREN, mem_dWEN, ex_MemRead, ex_wsel, id_rs, id_rt,
               id_uses_rt, ex_brtaken, id_jump, wb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush, halted
`ifdef PIPE_PERF_EN
        , input stall_cnt, flush_cnt
`endif
    );

    // Controller side.
    modport slave (
        input  ihit, dhit, mem_dREN, mem_dWEN, ex_MemRead, ex_wsel, id_rs, id_rt,
               id_uses_rt, ex_brtaken, id_jump, wb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush, halted
`ifdef PIPE_PERF_EN
        , output stall_cnt, flush_cnt
`endif
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
    import cpu_types_pkg::*;
(
    input  logic     ex_MemRead,
    input  regbits_t ex_wsel,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  logic     id_uses_rt,
    output logic     lu_hazard
);

    // $zero is hardwired, so a load targeting it never creates a dependency.
    always_comb begin
        lu_hazard = ex_MemRead && (ex_wsel != REG_ZERO) &&
                    ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: latch enables and
// flushes, PC enable and sticky halt. Define PIPE_PERF_EN to add saturating
// stall/flush counters.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
`ifdef PIPE_PERF_EN
#(
    parameter int unsigned CNT_W = 32
)
`endif
(
    input logic            CLK,
    input logic            RST,
    pipeline_ctrl_if.slave bus
);

    state_t state_q, state_d;
    logic   halted_q;
    logic   lu_hazard;
    logic   pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic   ifid_flush, idex_flush, exmem_flush, memwb_flush;

    hazard_detect u_hazard_detect (
        .ex_MemRead (bus.ex_MemRead),
        .ex_wsel    (bus.ex_wsel),
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .id_uses_rt (bus.id_uses_rt),
        .lu_hazard  (lu_hazard)
    );

    // State and sticky halt register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == HALT);
        end
    end

    // Next state and enable/flush decode, highest priority first.
    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;

        if (RST) begin
            state_d     = RUN;
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            {ifid_flush, idex_flush, exmem_flush, memwb_flush} = '1;
        end else if (state_q == HALT) begin
            state_d = HALT;
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        end else if (bus.wb_halt) begin
            state_d = HALT;
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        end else if ((bus.mem_dREN || bus.mem_dWEN) && !bus.dhit) begin
            // Freeze up to MEM; push a bubble into WB while the dcache works.
            state_d     = DWAIT;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else begin
            // Also covers DWAIT retiring on dhit: normal RUN rules apply this cycle.
            state_d = RUN;
            if (bus.ex_brtaken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (lu_hazard) begin
                // Hold IF/ID even on an icache miss; the bubble goes into ID/EX.
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (bus.id_jump) begin
                ifid_flush = 1'b1;
            end else if (!bus.ihit) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    // Drive the interface outputs.
    always_comb begin
        bus.pc_en       = pc_en;
        bus.ifid_en     = ifid_en;
        bus.idex_en     = idex_en;
        bus.exmem_en    = exmem_en;
        bus.memwb_en    = memwb_en;
        bus.ifid_flush  = ifid_flush;
        bus.idex_flush  = idex_flush;
        bus.exmem_flush = exmem_flush;
        bus.memwb_flush = memwb_flush;
        bus.halted      = halted_q;
    end

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             any_flush;

    assign any_flush = ifid_flush | idex_flush | exmem_flush | memwb_flush;

    // Saturating performance counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && (state_q != HALT) && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (any_flush && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipelined CPU.
- Drives the en/flush pairs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches, plus PC enable.
- Resolves icache/dcache waits, load-use hazards, taken branches/jumps and halt.
- Sits beside the datapath; consumes hit signals from the cache interface and stage fields from the latches.

Parameters:
- CNT_W, 32, width of performance counters (used only with PIPE_PERF_EN).

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous active-high reset
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- mem_dREN  in  1  EX/MEM latch holds a load
- mem_dWEN  in  1  EX/MEM latch holds a store
- ex_MemRead  in  1  ID/EX latch holds a load
- ex_wsel  in  5  ID/EX destination register
- id_rs  in  5  IF/ID rs field
- id_rt  in  5  IF/ID rt field
- id_uses_rt  in  1  IF/ID instruction reads rt
- ex_brtaken  in  1  branch in EX resolved taken
- id_jump  in  1  J/JAL/JR decoded in ID
- wb_halt  in  1  halt_o of MEM/WB latch
- pc_en  out  1  PC register load enable
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch advance enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch clear (bubble)
- halted  out  1  registered sticky halt to system
- stall_cnt  out  CNT_W  stall cycles (PIPE_PERF_EN only)
- flush_cnt  out  CNT_W  flush events (PIPE_PERF_EN only)

Behaviour:
- State register state_t: RUN, DWAIT, HALT.
- RST high: next state RUN, halted<=0; while RST is high, all en=0, all flush=1, pc_en=0.
- Outputs are combinational from state and inputs. halted is registered.
- Default (no condition active) in RUN: every en=1, every flush=0, pc_en=1.
- Conditions are evaluated in priority order; the first match wins for the signals it sets, and lower rules may add flushes only where stated.
- P1 HALT state: all en=0, all flush=0, pc_en=0, halted=1. Only RST leaves HALT.
- P2 wb_halt=1 in RUN/DWAIT: all en=0, pc_en=0; next state HALT; halted=1 from the next cycle.
- P3 (mem_dREN|mem_dWEN)&!dhit:
  - pc_en=0; ifid_en, idex_en, exmem_en = 0.
  - memwb_en=1, memwb_flush=1 (bubble into WB).
  - Next state DWAIT.
  - Remain in DWAIT until dhit.
- P4 dhit in DWAIT: next state RUN; apply the RUN rules (P5-P8) this cycle.
- P5 ex_brtaken=1: pc_en=1 (target load, regardless of ihit); ifid_flush=1, idex_flush=1; ID/EX and IF/ID contents are discarded.
- P6 load-use: ex_MemRead & ex_wsel!=0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt)).
  - pc_en=0, ifid_en=0, idex_flush=1.
  - Hazard lasts exactly 1 cycle, since the bubble clears ex_MemRead.
- P7 id_jump=1: pc_en=1, ifid_flush=1.
- P8 !ihit: pc_en=0, ifid_flush=1 (bubble into ID); later stages advance.
  - Combined with P6: pc_en=0, ifid_en=0 (hold IF/ID, no flush), idex_flush=1.
- Register $zero is never a hazard source.
- Flush overrides en for the same latch: a flushed latch loads zeros.

Optional Feature:
- Macro PIPE_PERF_EN.
- Defined:
  - stall_cnt increments on every cycle where pc_en=0 and state!=HALT.
  - flush_cnt increments once per cycle where any flush is asserted outside reset.
  - Both are reset to 0 and saturate at all-ones.
- Undefined: both ports absent and no counter logic is present.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state_t enum {RUN, DWAIT, HALT}.
  - Localparam REG_ZERO=5'd0.
  - Reuses regbits_t and word_t from cpu_types_pkg.
- Sub-module hazard_detect: combinational load-use compare (ex_MemRead, ex_wsel, id_rs, id_rt, id_uses_rt -> lu_hazard), instantiated once.

Test Plan:
- Reset: RST=1 for 2 cycles -> all flush=1, en=0, pc_en=0, halted=0; after release with ihit=1, all en=1, flush=0.
- Load-use: lw with ex_wsel=8, id_rs=8 -> exactly 1 cycle of pc_en=0, ifid_en=0, idex_flush=1; ex_wsel=0 -> no stall.
- Dcache miss: mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles of frozen latches with memwb_flush=1, state DWAIT; on the dhit cycle all en=1.
- Branch and icache miss: ex_brtaken=1 with ihit=0 -> pc_en=1, ifid_flush=1, idex_flush=1.
- Halt: wb_halt=1 -> halted=1 next cycle and stays 1 despite ihit/dhit toggling; RST clears it.
- PIPE_PERF_EN: 1 load-use stall plus a 3-cycle dmiss -> stall_cnt=4; a branch flush -> flush_cnt counts 1 per cycle with any flush.
